mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 100 ++++++++++
 tb/tb_mem_access_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory access controller: MAR/MDR registers with a small FSM that sequences
// single-cycle write strobes and fixed-latency reads, flagging protocol misuse.
module mem_access_ctrl #(
  parameter int DW     = 16,
  parameter int AW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] S_bus,
  input  logic          SMA,
  input  logic          SMD,
  input  logic          rd_req,
  input  logic          wr_req,
  input  logic          err_clr,
  output logic [DW-1:0] M_bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    RWAIT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t        state, state_n;
  logic [AW-1:0] mar;
  logic [DW-1:0] mdr;
  logic [2:0]    cnt;
  logic          idle;
  logic          viol;

  assign idle = (state == IDLE);
  // Simultaneous rd/wr in IDLE and any request while busy are both violations.
  assign viol = (idle & rd_req & wr_req) |
                (~idle & (SMA | SMD | rd_req | wr_req));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (wr_req)      state_n = WRITE;
        else if (rd_req) state_n = READ;
      end
      WRITE:   state_n = DONE;
      READ:    state_n = RWAIT;
      RWAIT:   if (cnt == 3'd0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar <= '0;
      mdr <= '0;
      cnt <= '0;
    end else begin
      if (idle && SMA) mar <= S_bus[AW-1:0];
      if (idle && SMD) mdr <= S_bus;
      if (state == READ) cnt <= LAT_M1;
      // cnt counts down through RWAIT; zero marks the cycle read data is valid.
      if (state == RWAIT) begin
        if (cnt != 3'd0) cnt <= cnt - 3'd1;
        else             mdr <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (viol)    err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

  assign M_bus     = mdr;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign busy      = ~idle;
  assign done      = (state == DONE);
  assign mem_we    = (state == WRITE);
  assign mem_re    = (state == READ);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a latency-accurate
// memory model (RD_LAT=2).
module tb_mem_access_ctrl;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] S_bus = '0;
  logic          SMA = 1'b0, SMD = 1'b0, rd_req = 1'b0, wr_req = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] M_bus, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          busy, done, err, mem_we, mem_re;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [DW-1:0] mem [0:255];
  logic [1:0]    re_pipe = '0;

  mem_access_ctrl #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .S_bus(S_bus), .SMA(SMA), .SMD(SMD),
    .rd_req(rd_req), .wr_req(wr_req), .err_clr(err_clr), .M_bus(M_bus),
    .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: writes land on the strobe edge; read data valid RD_LAT cycles after mem_re.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    re_pipe <= {re_pipe[0], mem_re};
  end
  assign mem_rdata = re_pipe[RD_LAT-1] ? mem[mem_addr[7:0]] : 16'hDEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({M_bus, mem_addr, mem_wdata, busy, done, err, mem_we, mem_re} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: M_bus=%h addr=%h wdata=%h busy=%b done=%b err=%b we=%b re=%b, expected all zero",
               M_bus, mem_addr, mem_wdata, busy, done, err, mem_we, mem_re);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_write();
    S_bus = 16'h0040; SMA = 1'b1; tick(); SMA = 1'b0;
    checks++;
    if (mem_addr !== 16'h0040) begin errors++; $display("FAIL load_mar: got %h expected 0040", mem_addr); end
    S_bus = 16'hBEEF; SMD = 1'b1; tick(); SMD = 1'b0;
    checks++;
    if (M_bus !== 16'hBEEF) begin errors++; $display("FAIL load_mdr: got %h expected beef", M_bus); end
    wr_req = 1'b1; tick(); wr_req = 1'b0;
    checks++;
    if ({mem_we, mem_re, busy, done} !== 4'b1010 || mem_addr !== 16'h0040 || mem_wdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_strobe: we=%b re=%b busy=%b done=%b addr=%h wdata=%h, expected we=1 re=0 busy=1 done=0 addr=0040 wdata=beef",
               mem_we, mem_re, busy, done, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if ({mem_we, done, busy} !== 3'b011) begin
      errors++; $display("FAIL write_done: we=%b done=%b busy=%b, expected 0 1 1", mem_we, done, busy);
    end
    tick();
    checks++;
    if ({busy, done, err} !== 3'b000 || mem[8'h40] !== 16'hBEEF) begin
      errors++; $display("FAIL write_idle: busy=%b done=%b err=%b mem=%h, expected 0 0 0 beef", busy, done, err, mem[8'h40]);
    end
  endtask

  task automatic test_read();
    S_bus = 16'h0000; SMD = 1'b1; tick(); SMD = 1'b0;
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    checks++;
    if ({mem_re, mem_we, done} !== 3'b100) begin
      errors++; $display("FAIL read_strobe: re=%b we=%b done=%b, expected 1 0 0", mem_re, mem_we, done);
    end
    for (int i = 0; i < RD_LAT; i++) begin
      tick();
      checks++;
      if ({mem_re, done, busy} !== 3'b001 || M_bus !== 16'h0000 || mem_addr !== 16'h0040) begin
        errors++;
        $display("FAIL read_wait%0d: re=%b done=%b busy=%b M_bus=%h addr=%h, expected 0 0 1 0000 0040",
                 i, mem_re, done, busy, M_bus, mem_addr);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || M_bus !== 16'hBEEF) begin
      errors++; $display("FAIL read_done: done=%b M_bus=%h, expected 1 beef", done, M_bus);
    end
    tick();
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL read_idle: busy=%b done=%b err=%b, expected 0 0 0", busy, done, err);
    end
  endtask

  task automatic test_simultaneous();
    S_bus = 16'h0050; SMA = 1'b1; SMD = 1'b1; tick(); SMA = 1'b0; SMD = 1'b0;
    checks++;
    if (mem_addr !== 16'h0050 || M_bus !== 16'h0050) begin
      errors++; $display("FAIL dual_load: addr=%h M_bus=%h, expected 0050 0050", mem_addr, M_bus);
    end
    rd_req = 1'b1; wr_req = 1'b1; tick(); rd_req = 1'b0; wr_req = 1'b0;
    checks++;
    if ({mem_we, mem_re, err} !== 3'b101) begin
      errors++; $display("FAIL simul_write: we=%b re=%b err=%b, expected 1 0 1", mem_we, mem_re, err);
    end
    tick();
    checks++;
    if ({done, mem_re} !== 2'b10) begin
      errors++; $display("FAIL simul_done: done=%b re=%b, expected 1 0", done, mem_re);
    end
    tick();
    checks++;
    if ({busy, mem_re, err} !== 3'b001 || mem[8'h50] !== 16'h0050) begin
      errors++; $display("FAIL simul_after: busy=%b re=%b err=%b mem=%h, expected 0 0 1 0050", busy, mem_re, err, mem[8'h50]);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err); end
  endtask

  task automatic test_busy_violation();
    S_bus = 16'h0040; SMA = 1'b1; tick(); SMA = 1'b0;
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    tick();
    S_bus = 16'h1234; SMA = 1'b1; tick(); SMA = 1'b0;
    checks++;
    if (mem_addr !== 16'h0040 || err !== 1'b1) begin
      errors++; $display("FAIL busy_sma: addr=%h err=%b, expected 0040 1", mem_addr, err);
    end
    wr_req = 1'b1; err_clr = 1'b1; tick(); wr_req = 1'b0; err_clr = 1'b0;
    checks++;
    if ({done, err} !== 2'b11 || M_bus !== 16'hBEEF) begin
      errors++; $display("FAIL busy_done: done=%b err=%b M_bus=%h, expected 1 1 beef", done, err, M_bus);
    end
    tick();
    checks++;
    if ({busy, mem_we} !== 2'b00) begin
      errors++; $display("FAIL busy_ignored_wr: busy=%b we=%b, expected 0 0", busy, mem_we);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_re} !== 3'b000 || M_bus !== 16'h0000 || mem_addr !== 16'h0000) begin
      errors++; $display("FAIL reset_mid_read: busy=%b done=%b re=%b M_bus=%h addr=%h, expected 0 0 0 0000 0000",
                         busy, done, mem_re, M_bus, mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_no_done%0d: got %b expected 0", i, done); end
    end
    rst_n = 1'b1;
    tick();
    S_bus = 16'h0060; SMA = 1'b1; tick(); SMA = 1'b0;
    S_bus = 16'hCAFE; SMD = 1'b1; tick(); SMD = 1'b0;
    wr_req = 1'b1; tick(); wr_req = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0060) begin
      errors++; $display("FAIL post_reset_write: we=%b addr=%h, expected 1 0060", mem_we, mem_addr);
    end
    tick();
    checks++;
    if (done !== 1'b1 || mem[8'h60] !== 16'hCAFE) begin
      errors++; $display("FAIL post_reset_done: done=%b mem=%h, expected 1 cafe", done, mem[8'h60]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic prev_done;
    int   n_we;
    prev_done = 1'b0;
    n_we = 0;
    wr_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (mem_we !== (i % 3 == 0) || done !== (i % 3 == 1) || mem_re !== 1'b0) begin
        errors++; $display("FAIL b2b_cycle%0d: we=%b done=%b re=%b, expected %b %b 0",
                           i, mem_we, done, mem_re, (i % 3 == 0), (i % 3 == 1));
      end
      checks++;
      if (prev_done === 1'b1 && done === 1'b1) begin
        errors++; $display("FAIL b2b_adjacent_done%0d: got done twice in a row, expected gap", i);
      end
      prev_done = done;
      if (mem_we === 1'b1) n_we++;
    end
    wr_req = 1'b0;
    checks++;
    if (n_we != 4) begin errors++; $display("FAIL b2b_count: got %0d accesses expected 4", n_we); end
    tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++;
    if ({busy, err} !== 2'b00) begin
      errors++; $display("FAIL b2b_end: busy=%b err=%b, expected 0 0", busy, err);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #1;
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_busy_violation();
    test_reset_mid_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
